// File: rtl/serial_add_pkg.sv
// serial_add_pkg
//   Shared definitions for the bit-serial add/subtract controller.
//   - SADD_W  : default operand/result width
//   - state_t : controller state encoding (IDLE, RUN, DONE), 2 bits
package serial_add_pkg;

  localparam int SADD_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_fa_cell.sv
// serial_fa_cell
//   One-bit full adder whose carry is held in a flop between bits.
//   Ports:
//     clk      in   rising-edge clock
//     rst_b    in   synchronous active-low reset (clears carry)
//     load     in   preload carry with cin_init instead of accumulating
//     cin_init in   carry value loaded at the start of an operation
//     x, y     in   current operand bits
//     s        out  combinational sum bit  x ^ y ^ carry
//     c_q      out  registered carry
module serial_fa_cell (
  input  logic clk,
  input  logic rst_b,
  input  logic load,
  input  logic cin_init,
  input  logic x,
  input  logic y,
  output logic s,
  output logic c_q
);

  assign s = x ^ y ^ c_q;

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      c_q <= 1'b0;
    end else if (load) begin
      c_q <= cin_init;
    end else begin
      c_q <= (x & y) | (x & c_q) | (y & c_q);
    end
  end

endmodule

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl
//   Word-level front end for a bit-serial adder/subtractor. Operands are
//   latched on an accepted start, streamed LSB-first through serial_fa_cell,
//   and the assembled result is published with a one-cycle done pulse.
//
//   Handshake: start is a request pulse, accepted on a rising edge only when
//   busy = 0 (otherwise it is dropped, not queued). busy rises on the
//   accepting edge and stays high through the done cycle; done is high for
//   exactly one cycle, W+1 cycles after the accepting edge, and sum/cout/ovf
//   are valid from that cycle until the next accepted start.
//
//   Ports:
//     clk, rst_b     clock, synchronous active-low reset
//     start, op_sub  request pulse, 0 = a + b / 1 = a - b
//     a, b           W-bit operands (sampled with start)
//     busy, done     status (registered)
//     sum, cout, ovf result, final carry, signed overflow (registered)
//     state_dbg      current FSM state (debug observation)
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int W = SADD_W
) (
  input  logic         clk,
  input  logic         rst_b,
  input  logic         start,
  input  logic         op_sub,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         ovf,
  output logic [1:0]   state_dbg
);

  localparam int CNT_W = (W > 2) ? $clog2(W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(W - 1);

  state_t             state, state_nxt;
  logic [W-1:0]       opa, opb, sum_sh;
  logic [CNT_W-1:0]   cnt;
  logic               c_msb;
  logic               busy_q, done_q, cout_q, ovf_q;
  logic [W-1:0]       sum_q;

  logic               accept, load, run, last_bit, finish;
  logic               fa_s, fa_c;

  // busy is a flop of its own so it can cover the done cycle, which the
  // FSM already spends back in IDLE.
  assign accept = start & (state == IDLE) & ~busy_q;

  serial_fa_cell u_fa (
    .clk      (clk),
    .rst_b    (rst_b),
    .load     (load),
    .cin_init (op_sub),
    .x        (run & opa[0]),
    .y        (run & opb[0]),
    .s        (fa_s),
    .c_q      (fa_c)
  );

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    run       = 1'b0;
    last_bit  = 1'b0;
    finish    = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          load      = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        run = 1'b1;
        if (cnt == CNT_LAST) begin
          last_bit  = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        finish    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      state  <= IDLE;
      opa    <= '0;
      opb    <= '0;
      sum_sh <= '0;
      cnt    <= '0;
      c_msb  <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      sum_q  <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      state  <= state_nxt;
      done_q <= finish;
      if (load) begin
        opa    <= a;
        opb    <= op_sub ? ~b : b;
        cnt    <= '0;
        busy_q <= 1'b1;
      end
      if (run) begin
        opa    <= opa >> 1;
        opb    <= opb >> 1;
        sum_sh <= {fa_s, sum_sh[W-1:1]};
        if (last_bit) begin
          // carry register now holds the carry into the MSB position
          c_msb <= fa_c;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
      if (finish) begin
        sum_q  <= sum_sh;
        cout_q <= fa_c;
        ovf_q  <= c_msb ^ fa_c;
      end
      if (done_q) begin
        busy_q <= 1'b0;
      end
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
  assign state_dbg = state;

endmodule

// File: tb/tb_serial_add_ctrl.sv
module tb_serial_add_ctrl;

  localparam int W = 8;

  logic         clk;
  logic         rst_b;
  logic         start;
  logic         op_sub;
  logic [W-1:0] a, b;
  logic         busy, done, cout, ovf;
  logic [W-1:0] sum;
  logic [1:0]   state_dbg;

  int n_cmp;
  int n_bad;
  logic [W-1:0] last_sum;

  serial_add_ctrl #(.W(W)) dut (
    .clk       (clk),
    .rst_b     (rst_b),
    .start     (start),
    .op_sub    (op_sub),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .state_dbg (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         sub;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] e_sum;
    logic         e_cout;
    logic         e_ovf;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Called at a negedge. Issues one start, waits for done (bounded), checks
  // latency, busy length, single-cycle done, held sum during RUN and result.
  task automatic run_op(input string name, input logic sub, input logic [W-1:0] va,
                        input logic [W-1:0] vb, input logic [W-1:0] e_sum,
                        input logic e_cout, input logic e_ovf);
    int lat;
    int busy_cyc;
    start  = 1'b1;
    op_sub = sub;
    a      = va;
    b      = vb;
    @(posedge clk);
    @(negedge clk);
    start    = 1'b0;
    a        = $urandom_range(0, 255);
    b        = $urandom_range(0, 255);
    lat      = 0;
    busy_cyc = 0;
    while (!done && lat < 40) begin
      if (busy) busy_cyc++;
      check({name, " sum_held"}, {24'b0, sum}, {24'b0, last_sum});
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    if (busy) busy_cyc++;
    check({name, " latency"}, lat, 9);
    check({name, " sum"}, {24'b0, sum}, {24'b0, e_sum});
    check({name, " cout"}, {31'b0, cout}, {31'b0, e_cout});
    check({name, " ovf"}, {31'b0, ovf}, {31'b0, e_ovf});
    @(negedge clk);
    check({name, " done_pulse"}, {31'b0, done}, 32'd0);
    check({name, " busy_cycles"}, busy_cyc, 10);
    check({name, " busy_fall"}, {31'b0, busy}, 32'd0);
    check({name, " sum_hold_after"}, {24'b0, sum}, {24'b0, e_sum});
    last_sum = e_sum;
  endtask

  task automatic check_reset_vals(input string name);
    check({name, " sum"},  {24'b0, sum}, 32'd0);
    check({name, " cout"}, {31'b0, cout}, 32'd0);
    check({name, " ovf"},  {31'b0, ovf}, 32'd0);
    check({name, " busy"}, {31'b0, busy}, 32'd0);
    check({name, " done"}, {31'b0, done}, 32'd0);
  endtask

  initial begin
    int n_done;
    n_cmp    = 0;
    n_bad    = 0;
    last_sum = '0;
    start    = 1'b0;
    op_sub   = 1'b0;
    a        = '0;
    b        = '0;

    vecs[0] = '{1'b0, 8'h35, 8'h4A, 8'h7F, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0};
    vecs[2] = '{1'b0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1};
    vecs[3] = '{1'b1, 8'h05, 8'h07, 8'hFE, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1};
    vecs[5] = '{1'b1, 8'h10, 8'h10, 8'h00, 1'b1, 1'b0};
    vecs[6] = '{1'b0, 8'h80, 8'h80, 8'h00, 1'b1, 1'b1};
    vecs[7] = '{1'b1, 8'h00, 8'h01, 8'hFF, 1'b0, 1'b0};

    // reset with random inputs toggling
    rst_b = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      start  = 1'($urandom_range(0, 1));
      op_sub = 1'($urandom_range(0, 1));
      a      = $urandom_range(0, 255);
      b      = $urandom_range(0, 255);
      @(posedge clk);
    end
    @(negedge clk);
    check_reset_vals("reset");
    check("reset state", {30'b0, state_dbg}, 32'd0);
    start = 1'b0;
    rst_b = 1'b1;
    @(negedge clk);

    // table-driven vectors, each start issued in the first idle cycle
    for (int i = 0; i < 8; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].sub, vecs[i].a, vecs[i].b,
             vecs[i].e_sum, vecs[i].e_cout, vecs[i].e_ovf);
    end

    // start while busy: second start 3 cycles in must be dropped
    start  = 1'b1;
    op_sub = 1'b0;
    a      = 8'h10;
    b      = 8'h20;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    start  = 1'b1;
    op_sub = 1'b1;
    a      = 8'hAA;
    b      = 8'h55;
    @(negedge clk);
    start  = 1'b0;
    n_done = 0;
    for (int i = 0; i < 30; i++) begin
      if (done) begin
        n_done++;
        check("busy_start sum", {24'b0, sum}, 32'h30);
        check("busy_start cout", {31'b0, cout}, 32'd0);
      end
      @(negedge clk);
    end
    check("busy_start done_count", n_done, 1);
    check("busy_start idle", {31'b0, busy}, 32'd0);
    last_sum = 8'h30;

    // reset mid-operation at RUN bit 4
    start  = 1'b1;
    op_sub = 1'b0;
    a      = 8'h12;
    b      = 8'h34;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (4) begin
      @(posedge clk);
      @(negedge clk);
    end
    check("mid_reset busy_before", {31'b0, busy}, 32'd1);
    rst_b = 1'b0;
    @(negedge clk);
    check_reset_vals("mid_reset");
    rst_b = 1'b1;
    n_done = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) n_done++;
    end
    check("mid_reset no_done", n_done, 0);
    last_sum = '0;
    run_op("after_reset", 1'b0, 8'h01, 8'h01, 8'h02, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
